// File: rtl/microwave_pkg.sv
// Shared state codes and helpers for the microwave controller.
// State encodings are also consumed by the VGA module via oState.
package microwave_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_LOAD_DUR  = 3'd1,
    S_LOAD_HEAT = 3'd2,
    S_READY     = 3'd3,
    S_COOK      = 3'd4,
    S_PAUSE     = 3'd5,
    S_DONE      = 3'd6,
    S_CLEAR     = 3'd7
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/microwave_control_rise_detect.sv
// Rising-edge detector for a debounced key.
// History resets high so a key held through reset gives no edge.
module riseDetect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/microwave_control.sv
// Microwave oven control FSM (Moore, registered outputs).
// Define DOOR_INTERLOCK_EN to let iDoorOpen block/pause cooking.
module microwave_control
  import microwave_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int DONE_HOLD_S     = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               iLoad,
  input  logic               iStart,
  input  logic               iCancel,
  input  logic               iDoorOpen,
  input  logic               iDone,
  output logic               oLoadDuration,
  output logic               oLoadHeat,
  output logic               oStart,
  output logic               oControlReset,
  output logic [STATE_W-1:0] oState,
  output logic               oDoneAlarm
);

  localparam int HOLD_CYCLES = DONE_HOLD_S * CLOCK_FREQUENCY;
  localparam int CNT_W       = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_dur_q;
  logic             ld_heat_q;
  logic             start_q;
  logic             ctl_rst_q;
  logic             alarm_q;

  logic load_rise;
  logic cancel_rise;
  logic door_ok;
  logic start_ok;

  riseDetect u_load_rise (
    .clk_i  (clock),
    .rst_ni (resetn),
    .sig_i  (iLoad),
    .rise_o (load_rise)
  );

  riseDetect u_cancel_rise (
    .clk_i  (clock),
    .rst_ni (resetn),
    .sig_i  (iCancel),
    .rise_o (cancel_rise)
  );

`ifdef DOOR_INTERLOCK_EN
  assign door_ok = ~iDoorOpen;
`else
  logic unused_door;
  assign unused_door = iDoorOpen;
  assign door_ok     = 1'b1;
`endif

  assign start_ok = iStart & door_ok;

  // Cancel wins over every other event in the states that accept it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (load_rise) state_d = S_LOAD_DUR;
      end
      S_LOAD_DUR: begin
        if (cancel_rise)    state_d = S_CLEAR;
        else if (load_rise) state_d = S_LOAD_HEAT;
      end
      S_LOAD_HEAT: begin
        if (cancel_rise)    state_d = S_CLEAR;
        else if (load_rise) state_d = S_READY;
      end
      S_READY: begin
        if (cancel_rise)   state_d = S_CLEAR;
        else if (start_ok) state_d = S_COOK;
      end
      S_COOK: begin
        if (cancel_rise)    state_d = S_CLEAR;
        else if (iDone)     state_d = S_DONE;
        else if (!start_ok) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (cancel_rise)   state_d = S_CLEAR;
        else if (start_ok) state_d = S_COOK;
      end
      S_DONE: begin
        if (cancel_rise)            state_d = S_CLEAR;
        else if (cnt_q == CNT_LAST) state_d = S_CLEAR;
        else                        cnt_d = cnt_q + 1'b1;
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ld_dur_q  <= 1'b0;
      ld_heat_q <= 1'b0;
      start_q   <= 1'b0;
      ctl_rst_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_dur_q  <= (state_d == S_LOAD_DUR);
      ld_heat_q <= (state_d == S_LOAD_HEAT);
      start_q   <= (state_d == S_COOK);
      ctl_rst_q <= (state_d == S_CLEAR);
      alarm_q   <= (state_d == S_DONE);
    end
  end

  assign oState        = state_q;
  assign oLoadDuration = ld_dur_q;
  assign oLoadHeat     = ld_heat_q;
  assign oStart        = start_q;
  assign oControlReset = ctl_rst_q;
  assign oDoneAlarm    = alarm_q;

endmodule

// File: tb/tb_microwave_control.sv
// Scoreboard bench for microwave_control.
// Small timing: 10 cycles/s, 2 s done hold.
module tb_microwave_control;

  localparam int CF = 10;
  localparam int DH = 2;
`ifdef DOOR_INTERLOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clock;
  logic       resetn;
  logic       iLoad, iStart, iCancel, iDoorOpen, iDone;
  logic       oLoadDuration, oLoadHeat, oStart;
  logic       oControlReset, oDoneAlarm;
  logic [2:0] oState;

  int n_run;
  int n_fail;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;
  sb_t sb_q[$];

  microwave_control #(
    .CLOCK_FREQUENCY (CF),
    .DONE_HOLD_S     (DH)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .iLoad         (iLoad),
    .iStart        (iStart),
    .iCancel       (iCancel),
    .iDoorOpen     (iDoorOpen),
    .iDone         (iDone),
    .oLoadDuration (oLoadDuration),
    .oLoadHeat     (oLoadHeat),
    .oStart        (oStart),
    .oControlReset (oControlReset),
    .oState        (oState),
    .oDoneAlarm    (oDoneAlarm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] s);
    return {s, s == 3'd1, s == 3'd2, s == 3'd4,
            s == 3'd7, s == 3'd6};
  endfunction

  function automatic logic [7:0] observed();
    return {oState, oLoadDuration, oLoadHeat, oStart,
            oControlReset, oDoneAlarm};
  endfunction

  task automatic push(input string tag, input logic [2:0] s);
    sb_t e;
    e.tag = tag;
    e.exp = model(s);
    sb_q.push_back(e);
  endtask

  task automatic pop_chk();
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, {24'd0, observed()}, {24'd0, e.exp});
    end
  endtask

  task automatic tick(input string tag,
                      input logic ld, input logic st,
                      input logic cn, input logic dr,
                      input logic dn, input logic [2:0] s);
    iLoad     = ld;
    iStart    = st;
    iCancel   = cn;
    iDoorOpen = dr;
    iDone     = dn;
    push(tag, s);
    @(posedge clock);
    #1;
    pop_chk();
  endtask

  task automatic load3();
    tick("ld1", 1, 0, 0, 0, 0, 3'd1);
    tick("ld1_lo", 0, 0, 0, 0, 0, 3'd1);
    tick("ld2", 1, 0, 0, 0, 0, 3'd2);
    tick("ld2_lo", 0, 0, 0, 0, 0, 3'd2);
    tick("ld3", 1, 0, 0, 0, 0, 3'd3);
    tick("ld3_lo", 0, 0, 0, 0, 0, 3'd3);
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    iLoad     = 0;
    iStart    = 0;
    iCancel   = 0;
    iDoorOpen = 0;
    iDone     = 0;
    resetn    = 1'b1;
    #1 resetn = 1'b0;
    #1;
    push("reset", 3'd0);
    pop_chk();
    @(posedge clock);
    @(posedge clock);
    #1 resetn = 1'b1;

    tick("idle", 0, 0, 0, 0, 0, 3'd0);
    load3();
    tick("rdy_ld_ign", 1, 0, 0, 0, 0, 3'd3);
    tick("rdy_ld_lo", 0, 0, 0, 0, 0, 3'd3);
    tick("rdy_door", 0, 1, 0, 1, 0, LOCK ? 3'd3 : 3'd4);
    tick("cook", 0, 1, 0, 0, 0, 3'd4);
    tick("cook_door", 0, 1, 0, 1, 0, LOCK ? 3'd5 : 3'd4);
    tick("cook_rsm", 0, 1, 0, 0, 0, 3'd4);
    tick("pause", 0, 0, 0, 0, 0, 3'd5);
    tick("pause_hold", 0, 0, 0, 0, 1, 3'd5);
    tick("resume", 0, 1, 0, 0, 0, 3'd4);
    tick("done", 0, 1, 0, 0, 1, 3'd6);
    for (int i = 0; i < CF * DH - 1; i++) begin
      tick("done_hold", i == 5, 0, 0, 0, i == 7, 3'd6);
    end
    tick("clear", 0, 0, 0, 0, 0, 3'd7);
    tick("back_idle", 0, 0, 0, 0, 0, 3'd0);

    load3();
    tick("cook2", 0, 1, 0, 0, 0, 3'd4);
    tick("cancel_vs_done", 0, 1, 1, 0, 1, 3'd7);
    tick("cancel_idle", 0, 0, 0, 0, 0, 3'd0);

    tick("ld_a", 1, 0, 0, 0, 0, 3'd1);
    tick("ld_a_lo", 0, 0, 0, 0, 0, 3'd1);
    tick("ld_and_cn", 1, 0, 1, 0, 0, 3'd7);
    tick("ld_cn_idle", 0, 0, 0, 0, 0, 3'd0);

    load3();
    tick("rdy_done_ign", 0, 0, 0, 0, 1, 3'd3);
    tick("rdy_cancel", 0, 0, 1, 0, 0, 3'd7);
    tick("rdy_can_idle", 0, 0, 0, 0, 0, 3'd0);

    load3();
    tick("cook3", 0, 1, 0, 0, 0, 3'd4);
    iLoad = 1'b1;
    #2 resetn = 1'b0;
    #1;
    push("async_rst", 3'd0);
    pop_chk();
    @(posedge clock);
    #1 resetn = 1'b1;
    tick("rel_hold1", 1, 0, 0, 0, 0, 3'd0);
    tick("rel_hold2", 1, 0, 0, 0, 0, 3'd0);
    tick("rel_lo", 0, 0, 0, 0, 0, 3'd0);
    tick("rel_edge", 1, 0, 0, 0, 0, 3'd1);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
